// File: rtl/instr_encoder.sv
// instr_encoder: MIPS word encoder feeding an in-order output FIFO with a word-address counter.
// Optional macro ENC_ERR_CHECK_EN: ops 20-31 are accepted but dropped, and err pulses.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   addr_q;
  logic          rdy_q;

  logic          r_t;
  logic          i_t;
  logic          j_t;
  logic [5:0]    opc;
  logic [5:0]    fn;
  logic [4:0]    rs_f;
  logic [4:0]    rt_f;
  logic [4:0]    rd_f;
  logic [31:0]   word;

  logic          accept;
  logic          push;
  logic          pop;

  // Per-op field selection: format class, opcode/funct, forced-zero fields
  always_comb begin
    r_t  = 1'b0;
    i_t  = 1'b0;
    j_t  = 1'b0;
    opc  = 6'h00;
    fn   = 6'h00;
    rs_f = in_rs;
    rt_f = in_rt;
    rd_f = in_rd;
    case (in_op)
      5'd0:  begin r_t = 1'b1; fn = 6'h20; end
      5'd1:  begin r_t = 1'b1; fn = 6'h21; end
      5'd2:  begin r_t = 1'b1; fn = 6'h22; end
      5'd3:  begin r_t = 1'b1; fn = 6'h24; end
      5'd4:  begin r_t = 1'b1; fn = 6'h25; end
      5'd5:  begin r_t = 1'b1; fn = 6'h2A; end
      5'd6: begin
        r_t  = 1'b1;
        fn   = 6'h08;
        rt_f = 5'd0;
        rd_f = 5'd0;
      end
      5'd7: begin
        r_t  = 1'b1;
        fn   = 6'h0C;
        rs_f = 5'd0;
        rt_f = 5'd0;
        rd_f = 5'd0;
      end
      5'd8:  begin i_t = 1'b1; opc = 6'h08; end
      5'd9:  begin i_t = 1'b1; opc = 6'h09; end
      5'd10: begin i_t = 1'b1; opc = 6'h0D; end
      5'd11: begin i_t = 1'b1; opc = 6'h0B; end
      5'd12: begin
        i_t  = 1'b1;
        opc  = 6'h0F;
        rs_f = 5'd0;
      end
      5'd13: begin i_t = 1'b1; opc = 6'h23; end
      5'd14: begin i_t = 1'b1; opc = 6'h2B; end
      5'd15: begin i_t = 1'b1; opc = 6'h04; end
      5'd16: begin i_t = 1'b1; opc = 6'h05; end
      5'd17: begin j_t = 1'b1; opc = 6'h02; end
      5'd18: begin j_t = 1'b1; opc = 6'h03; end
      default: ;
    endcase
  end

  // Pack the selected fields; NOP and unsupported ops fall through to zero
  always_comb begin
    word = 32'h0;
    unique case (1'b1)
      r_t:     word = {6'h00, rs_f, rt_f, rd_f, 5'd0, fn};
      i_t:     word = {opc, rs_f, rt_f, in_imm};
      j_t:     word = {opc, in_target};
      default: word = 32'h0;
    endcase
  end

  assign in_ready  = rdy_q && (level < FULL) && !flush;
  assign out_valid = (level != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign out_addr  = addr_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

`ifdef ENC_ERR_CHECK_EN
  logic sup;
  logic err_q;

  assign sup  = (in_op <= 5'd19);
  assign push = accept && sup;
  assign err  = err_q;

  // Rejected ops raise err for the cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !sup;
    end
  end
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  // Storage array, written at the tail on each push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Pointers, occupancy, address counter and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      addr_q <= BASE_ADDR;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        addr_q <= BASE_ADDR;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          addr_q <= addr_q + 32'd4;
        end
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder
// against a queue-based reference model.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int RFN [8] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h2A, 'h08, 'h0C};
  localparam int IOP [9] = '{'h08, 'h09, 'h0D, 'h0B, 'h0F, 'h23, 'h2B, 'h04, 'h05};

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [2:0]  level;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_addr;
  logic        w_err;
  logic [2:0]  w_level;

  logic [31:0] mq [$];
  logic [31:0] maddr;
  bit          up;
  bit          exp_err;
  int          tests;
  int          fails;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .level(level)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFFFFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr),
    .err(w_err), .level(w_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] opv, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [15:0] imm, input logic [25:0] tg);
    int op;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] d;
    op = int'(opv);
    s = 32'(rs);
    t = 32'(rt);
    d = 32'(rd);
    if (op < 8) begin
      if (op == 6) begin t = 0; d = 0; end
      if (op == 7) begin s = 0; t = 0; d = 0; end
      return (s << 21) | (t << 16) | (d << 11) | 32'(RFN[op]);
    end
    if (op < 17) begin
      if (op == 12) s = 0;
      return (32'(IOP[op-8]) << 26) | (s << 21) | (t << 16) | 32'(imm);
    end
    if (op < 19) return (32'(op - 15) << 26) | 32'(tg);
    return 32'h0;
  endfunction

  task automatic drive(input bit v, input int op);
    in_valid  = v;
    in_op     = 5'(op);
    in_rs     = 5'($urandom);
    in_rt     = 5'($urandom);
    in_rd     = 5'($urandom);
    in_imm    = 16'($urandom);
    in_target = 26'($urandom);
  endtask

  // Advance model by one edge from the current inputs, then clock the DUT.
  task automatic step();
    bit rdy;
    bit acc;
    bit pp;
    bit sup;
    rdy = up && !flush && (mq.size() < DEPTH);
    acc = in_valid && rdy;
    pp  = (mq.size() != 0) && out_ready && !flush;
    sup = (int'(in_op) < 20);
    exp_err = 1'b0;
    if (flush) begin
      mq.delete();
      maddr = BASE;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        maddr = maddr + 32'd4;
      end
      if (acc) begin
`ifdef ENC_ERR_CHECK_EN
        if (sup) mq.push_back(enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target));
        exp_err = !sup;
`else
        mq.push_back(enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target));
`endif
      end
    end
    up = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 0);
    mq.delete();
    maddr = BASE;
    up = 1'b0;
    #12;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b ov=%b lvl=%0d err=%b exp 0 0 0 0",
               in_ready, out_valid, level, err);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge got %b exp 0", in_ready);
    end
    step();
    tests++;
    if (in_ready !== 1'b1 || out_addr !== BASE || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL ready_after_edge got rdy=%b addr=%h instr=%h exp 1 %h 0",
               in_ready, out_addr, out_instr, BASE);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b0;
    drive(1, 8);
    in_rs = 5'd1;
    in_rt = 5'd2;
    in_rd = 5'd9;
    in_imm = 16'h0005;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL addi_ready got %b exp 1", in_ready);
    end
    step();
    drive(0, 0);
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'h20220005 || out_addr !== 32'h00400000 || level !== 3'd1) begin
      fails++;
      $display("FAIL addi_word got ov=%b instr=%h addr=%h lvl=%0d exp 1 20220005 00400000 1",
               out_valid, out_instr, out_addr, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'h00400004) begin
      fails++;
      $display("FAIL addi_pop got lvl=%0d ov=%b addr=%h exp 0 0 00400004", level, out_valid, out_addr);
    end
  endtask

  task automatic test_two();
    do_flush();
    out_ready = 1'b1;
    drive(1, 0);
    in_rs = 5'd1;
    in_rt = 5'd2;
    in_rd = 5'd3;
    step();
    drive(1, 17);
    in_target = 26'h0100000;
    #1;
    tests++;
    if (out_instr !== 32'h00221820 || out_addr !== 32'h00400000) begin
      fails++;
      $display("FAIL add_word got %h@%h exp 00221820@00400000", out_instr, out_addr);
    end
    step();
    drive(0, 0);
    #1;
    tests++;
    if (out_instr !== 32'h08100000 || out_addr !== 32'h00400004) begin
      fails++;
      $display("FAIL j_word got %h@%h exp 08100000@00400004", out_instr, out_addr);
    end
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL two_drain got ov=%b instr=%h exp 0 0", out_valid, out_instr);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp [4];
    logic [31:0] ea;
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, 19));
      #1;
      tests++;
      if (in_ready !== (i < 4)) begin
        fails++;
        $display("FAIL full_ready[%0d] got %b exp %b", i, in_ready, (i < 4));
      end
      if (i < 4) exp[i] = enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
      if (i < 4) step();
    end
    tests++;
    if (level !== 3'd4 || out_instr !== exp[0]) begin
      fails++;
      $display("FAIL full_level got lvl=%0d instr=%h exp 4 %h", level, out_instr, exp[0]);
    end
    step();
    tests++;
    if (out_instr !== exp[0] || level !== 3'd4) begin
      fails++;
      $display("FAIL full_stable got instr=%h lvl=%0d exp %h 4", out_instr, level, exp[0]);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_passthru got %b exp 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      ea = BASE + 32'(4 * i);
      #1;
      tests++;
      if (out_instr !== exp[i] || out_addr !== ea) begin
        fails++;
        $display("FAIL full_order[%0d] got %h@%h exp %h@%h", i, out_instr, out_addr, exp[i], ea);
      end
      step();
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL full_drain got lvl=%0d exp 0", level);
    end
  endtask

  task automatic test_unsupported();
    do_flush();
    out_ready = 1'b0;
    drive(1, 25);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL unsup_ready got %b exp 1", in_ready);
    end
    step();
    drive(0, 0);
`ifdef ENC_ERR_CHECK_EN
    tests++;
    if (err !== 1'b1 || level !== 3'd0) begin
      fails++;
      $display("FAIL unsup_err got err=%b lvl=%0d exp 1 0", err, level);
    end
    step();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL unsup_pulse got err=%b exp 0", err);
    end
`else
    tests++;
    if (err !== 1'b0 || level !== 3'd1 || out_valid !== 1'b1 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL unsup_push got err=%b lvl=%0d ov=%b instr=%h exp 0 1 1 0",
               err, level, out_valid, out_instr);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
  endtask

  task automatic test_flush();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom_range(0, 19));
      step();
    end
    drive(0, 0);
    #1;
    tests++;
    if (level !== 3'd2) begin
      fails++;
      $display("FAIL flush_pre got lvl=%0d exp 2", level);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1, 3);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_ready got %b exp 0", in_ready);
    end
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 0);
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear got lvl=%0d ov=%b err=%b exp 0 0 0", level, out_valid, err);
    end
    drive(1, 8);
    step();
    drive(0, 0);
    tests++;
    if (out_addr !== 32'h00400000 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_addr got addr=%h ov=%b exp 00400000 1", out_addr, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ei;
    bit          er;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, $urandom % 32);
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      #1;
      ei = (mq.size() != 0) ? mq[0] : 32'h0;
      er = up && !flush && (mq.size() < DEPTH);
      tests++;
      if (in_ready !== er || out_valid !== (mq.size() != 0) || level !== 3'(mq.size())) begin
        fails++;
        $display("FAIL rand_ctl[%0d] got rdy=%b ov=%b lvl=%0d exp %b %b %0d",
                 c, in_ready, out_valid, level, er, (mq.size() != 0), mq.size());
      end
      tests++;
      if (out_instr !== ei || out_addr !== maddr) begin
        fails++;
        $display("FAIL rand_data[%0d] got %h@%h exp %h@%h", c, out_instr, out_addr, ei, maddr);
      end
      step();
      tests++;
      if (err !== exp_err) begin
        fails++;
        $display("FAIL rand_err[%0d] got %b exp %b", c, err, exp_err);
      end
    end
    flush = 1'b0;
    drive(0, 0);
    out_ready = 1'b0;
    do_flush();
  endtask

  task automatic test_midreset();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 19));
      step();
    end
    drive(0, 0);
    #1;
    tests++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL mrst_pre got lvl=%0d exp 3", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mrst_async got ov=%b lvl=%0d rdy=%b exp 0 0 0", out_valid, level, in_ready);
    end
    mq.delete();
    maddr = BASE;
    up = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_addr !== 32'h00400000 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mrst_release got rdy=%b addr=%h ov=%b exp 1 00400000 0",
               in_ready, out_addr, out_valid);
    end
    drive(1, 0);
    in_rs = 5'd1;
    in_rt = 5'd2;
    in_rd = 5'd3;
    step();
    drive(0, 0);
    tests++;
    if (out_instr !== 32'h00221820 || out_addr !== 32'h00400000 || level !== 3'd1) begin
      fails++;
      $display("FAIL mrst_next got %h@%h lvl=%0d exp 00221820@00400000 1", out_instr, out_addr, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 19));
      step();
    end
    drive(0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ea = 32'hFFFFFFF8 + 32'(4 * i);
      #1;
      tests++;
      if (w_out_addr !== ea || w_out_instr !== mq[0]) begin
        fails++;
        $display("FAIL wrap_addr[%0d] got %h@%h exp %h@%h", i, w_out_instr, w_out_addr, mq[0], ea);
      end
      step();
    end
    out_ready = 1'b0;
    tests++;
    if (w_out_addr !== 32'h00000004 || w_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end got addr=%h ov=%b exp 00000004 0", w_out_addr, w_out_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_addi();
    test_two();
    test_full();
    test_unsupported();
    test_flush();
    test_random();
    test_midreset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
